// File: rtl/generatore_vga_pkg.sv
// Shared definitions for the VGA timing generator.
// - fase_t: line/frame phase (visible, front porch, sync, back porch)
// - CONT_W / CONT_MAX: width and largest value of the pixel/line counters
// - DEF_*: default timing for 800x600@72 Hz with a 50 MHz pixel clock
// - totale(): total period of one axis from its four phase lengths
package generatore_vga_pkg;

    typedef enum logic [1:0] {
        FASE_VIS = 2'd0,
        FASE_FP  = 2'd1,
        FASE_SYN = 2'd2,
        FASE_BP  = 2'd3
    } fase_t;

    localparam int CONT_W   = 11;
    localparam int CONT_MAX = 2047;

    localparam int DEF_H_VIS     = 800;
    localparam int DEF_H_FP      = 56;
    localparam int DEF_H_SYNC    = 120;
    localparam int DEF_H_BP      = 64;
    localparam int DEF_V_VIS     = 600;
    localparam int DEF_V_FP      = 37;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BP      = 23;
    localparam int DEF_DIV_PIXEL = 1;

    function automatic int totale(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/generatore_vga_contatore_fase.sv
// One timing axis: a counter 0..TOT-1 plus the phase FSM that follows it.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   avanza     : advance by one position this cycle
//   conteggio  : current position on the axis
//   fase       : current phase (VIS/FP/SYN/BP), always describes conteggio
module contatore_fase
    import generatore_vga_pkg::*;
#(
    parameter int VIS  = DEF_H_VIS,
    parameter int FP   = DEF_H_FP,
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP   = DEF_H_BP,
    parameter int W    = CONT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         avanza,
    output logic [W-1:0] conteggio,
    output fase_t        fase
);

    localparam int TOT = totale(VIS, FP, SYNC, BP);

    // Last position of each phase; the FSM moves on when it advances past it.
    localparam logic [W-1:0] FINE_VIS = W'(VIS - 1);
    localparam logic [W-1:0] FINE_FP  = W'(VIS + FP - 1);
    localparam logic [W-1:0] FINE_SYN = W'(VIS + FP + SYNC - 1);
    localparam logic [W-1:0] FINE_TOT = W'(TOT - 1);

    fase_t stato;
    fase_t stato_succ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conteggio <= '0;
        end else if (avanza) begin
            if (conteggio == FINE_TOT) begin
                conteggio <= '0;
            end else begin
                conteggio <= conteggio + W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stato <= FASE_VIS;
        end else begin
            stato <= stato_succ;
        end
    end

    // Next state: each phase ends on an advance at its last position
    always_comb begin
        stato_succ = stato;
        if (avanza) begin
            case (stato)
                FASE_VIS: if (conteggio == FINE_VIS) stato_succ = FASE_FP;
                FASE_FP:  if (conteggio == FINE_FP)  stato_succ = FASE_SYN;
                FASE_SYN: if (conteggio == FINE_SYN) stato_succ = FASE_BP;
                FASE_BP:  if (conteggio == FINE_TOT) stato_succ = FASE_VIS;
                default:  stato_succ = FASE_VIS;
            endcase
        end
    end

    // Output: phase is exposed directly
    always_comb begin
        fase = stato;
    end

endmodule

// File: rtl/generatore_vga.sv
// VGA timing generator: pixel prescaler, horizontal and vertical counters
// with phase FSMs, and a registered output stage.
// Ports:
//   CLK, RST         : system clock, asynchronous active-high reset
//   ABILITA          : run enable; 0 freezes everything
//   X_CONTROLLO      : pixel column (raw, blanking included)
//   Y_CONTROLLO      : pixel line (raw, blanking included)
//   HSYNC, VSYNC     : active-high sync pulses
//   VISIBILE         : pixel lies in the active area
//   INIZIO_QUADRO    : one-CLK pulse after the tick that presents pixel (0,0)
//   CONTATORE_QUADRI : frame-start count, wraps at 256
// All pixel outputs are loaded together on a tick from the pre-advance
// counters and phases, so X/Y/HSYNC/VSYNC/VISIBILE always describe the
// same pixel, one tick behind the counters.
module generatore_vga
    import generatore_vga_pkg::*;
#(
    parameter int H_VIS     = DEF_H_VIS,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VIS     = DEF_V_VIS,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int DIV_PIXEL = DEF_DIV_PIXEL
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ABILITA,
    output logic [10:0] X_CONTROLLO,
    output logic [10:0] Y_CONTROLLO,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        VISIBILE,
    output logic        INIZIO_QUADRO,
    output logic [7:0]  CONTATORE_QUADRI
);

    localparam int H_TOT = totale(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = totale(V_VIS, V_FP, V_SYNC, V_BP);

    if (H_TOT > CONT_MAX) begin : g_h_troppo
        $error("generatore_vga: H_TOT does not fit the 11-bit column counter");
    end
    if (V_TOT > CONT_MAX) begin : g_v_troppo
        $error("generatore_vga: V_TOT does not fit the 11-bit line counter");
    end
    if (DIV_PIXEL < 1 || DIV_PIXEL > 4) begin : g_div_errato
        $error("generatore_vga: DIV_PIXEL must be in 1..4");
    end

    localparam logic [1:0]        PRESC_FINE = 2'(DIV_PIXEL - 1);
    localparam logic [CONT_W-1:0] H_ULTIMO   = CONT_W'(H_TOT - 1);

    logic [1:0]        presc;
    logic              tick;
    logic              fine_riga;
    logic              origine;
    logic [CONT_W-1:0] hc;
    logic [CONT_W-1:0] vc;
    fase_t             h_fase;
    fase_t             v_fase;

    // Pixel tick: one CLK in DIV_PIXEL while enabled
    assign tick      = ABILITA && (presc == PRESC_FINE);
    assign fine_riga = tick && (hc == H_ULTIMO);
    assign origine   = tick && (hc == '0) && (vc == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else if (ABILITA) begin
            presc <= tick ? 2'd0 : presc + 2'd1;
        end
    end

    contatore_fase #(
        .VIS  (H_VIS),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .W    (CONT_W)
    ) u_orizzontale (
        .clk       (CLK),
        .rst       (RST),
        .avanza    (tick),
        .conteggio (hc),
        .fase      (h_fase)
    );

    // Lines advance only when the column counter wraps
    contatore_fase #(
        .VIS  (V_VIS),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .W    (CONT_W)
    ) u_verticale (
        .clk       (CLK),
        .rst       (RST),
        .avanza    (fine_riga),
        .conteggio (vc),
        .fase      (v_fase)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            X_CONTROLLO      <= '0;
            Y_CONTROLLO      <= '0;
            HSYNC            <= 1'b0;
            VSYNC            <= 1'b0;
            VISIBILE         <= 1'b0;
            INIZIO_QUADRO    <= 1'b0;
            CONTATORE_QUADRI <= '0;
        end else begin
            // Re-evaluated every CLK so the pulse is one CLK wide even
            // when a pixel spans several CLKs
            INIZIO_QUADRO <= origine;
            if (origine) begin
                CONTATORE_QUADRI <= CONTATORE_QUADRI + 8'd1;
            end
            if (tick) begin
                X_CONTROLLO <= hc;
                Y_CONTROLLO <= vc;
                HSYNC       <= (h_fase == FASE_SYN);
                VSYNC       <= (v_fase == FASE_SYN);
                VISIBILE    <= (h_fase == FASE_VIS) && (v_fase == FASE_VIS);
            end
        end
    end

endmodule

// File: tb/tb_generatore_vga.sv
// Bench for generatore_vga: three instances sharing CLK/RST/ABILITA
//   dut_d: default 800x600 timing, DIV_PIXEL=1
//   dut_s: small 15x8 timing,      DIV_PIXEL=1
//   dut_p: small 15x8 timing,      DIV_PIXEL=2
// Reference: ticks since reset, with pixel position derived arithmetically.
module tb_generatore_vga;

  localparam int SH_VIS = 8, SH_FP = 2, SH_SYNC = 3, SH_BP = 2;
  localparam int SV_VIS = 4, SV_FP = 1, SV_SYNC = 2, SV_BP = 1;
  localparam int S_FRAME = 15 * 8;
  localparam int D_FRAME = 1040 * 666;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic ABILITA = 1'b0;
  always #5 CLK = ~CLK;

  logic [10:0] d_x, d_y, s_x, s_y, p_x, p_y;
  logic d_hs, d_vs, d_vis, d_iq;
  logic s_hs, s_vs, s_vis, s_iq;
  logic p_hs, p_vs, p_vis, p_iq;
  logic [7:0] d_cnt, s_cnt, p_cnt;
  logic [33:0] d_vec, s_vec, p_vec;
  assign d_vec = {d_x, d_y, d_hs, d_vs, d_vis, d_iq, d_cnt};
  assign s_vec = {s_x, s_y, s_hs, s_vs, s_vis, s_iq, s_cnt};
  assign p_vec = {p_x, p_y, p_hs, p_vs, p_vis, p_iq, p_cnt};

  generatore_vga dut_d (
    .CLK(CLK), .RST(RST), .ABILITA(ABILITA),
    .X_CONTROLLO(d_x), .Y_CONTROLLO(d_y), .HSYNC(d_hs), .VSYNC(d_vs),
    .VISIBILE(d_vis), .INIZIO_QUADRO(d_iq), .CONTATORE_QUADRI(d_cnt)
  );

  generatore_vga #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP), .DIV_PIXEL(1)
  ) dut_s (
    .CLK(CLK), .RST(RST), .ABILITA(ABILITA),
    .X_CONTROLLO(s_x), .Y_CONTROLLO(s_y), .HSYNC(s_hs), .VSYNC(s_vs),
    .VISIBILE(s_vis), .INIZIO_QUADRO(s_iq), .CONTATORE_QUADRI(s_cnt)
  );

  generatore_vga #(
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP), .DIV_PIXEL(2)
  ) dut_p (
    .CLK(CLK), .RST(RST), .ABILITA(ABILITA),
    .X_CONTROLLO(p_x), .Y_CONTROLLO(p_y), .HSYNC(p_hs), .VSYNC(p_vs),
    .VISIBILE(p_vis), .INIZIO_QUADRO(p_iq), .CONTATORE_QUADRI(p_cnt)
  );

  // ---------------- reference model ----------------
  int m1_t = 0;        // ticks since reset, DIV_PIXEL=1
  bit m1_pulse = 1'b0; // small timing: last edge presented (0,0)
  bit d_pulse = 1'b0;  // default timing: last edge presented (0,0)
  int m2_ph = 0;       // CLKs into the current pixel, DIV_PIXEL=2
  int m2_t = 0;
  bit m2_pulse = 1'b0;
  int cyc = 0;         // CLK edges since reset release
  logic [7:0] exp_q[$];

  always @(posedge CLK) begin
    if (RST) begin
      m1_t <= 0; m1_pulse <= 1'b0; d_pulse <= 1'b0;
      m2_ph <= 0; m2_t <= 0; m2_pulse <= 1'b0;
      cyc <= 0;
      exp_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (ABILITA) begin
        m1_t <= m1_t + 1;
        m1_pulse <= ((m1_t % S_FRAME) == 0);
        d_pulse <= ((m1_t % D_FRAME) == 0);
        if ((m1_t % S_FRAME) == 0) exp_q.push_back(8'(((m1_t / S_FRAME) + 1) % 256));
        if (m2_ph == 1) begin
          m2_ph <= 0;
          m2_t <= m2_t + 1;
          m2_pulse <= ((m2_t % S_FRAME) == 0);
        end else begin
          m2_ph <= m2_ph + 1;
          m2_pulse <= 1'b0;
        end
      end else begin
        m1_pulse <= 1'b0; d_pulse <= 1'b0; m2_pulse <= 1'b0;
      end
    end
  end

  // Expected output bundle after t ticks; the (t-1)th pixel is on display.
  function automatic logic [33:0] expect_vec(input int t, input bit pulse,
      input int hv, input int hf, input int hs, input int hb,
      input int vv, input int vf, input int vs, input int vb);
    int ht, vt, k, x, y, fr;
    logic e_hs, e_vs, e_vis;
    if (t == 0) return '0;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    k = t - 1;
    x = k % ht;
    y = (k / ht) % vt;
    fr = (k / (ht * vt)) + 1;
    e_hs = (x >= hv + hf) && (x < hv + hf + hs);
    e_vs = (y >= vv + vf) && (y < vv + vf + vs);
    e_vis = (x < hv) && (y < vv);
    return {11'(x), 11'(y), e_hs, e_vs, e_vis, pulse, 8'(fr % 256)};
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int pulses_s = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b vis=%b iq=%b cnt=%0d expected x=%0d y=%0d hs=%b vs=%b vis=%b iq=%b cnt=%0d at %0t",
               name, act[33:23], act[22:12], act[11], act[10], act[9], act[8], act[7:0],
               exp[33:23], exp[22:12], exp[11], exp[10], exp[9], exp[8], exp[7:0], $time);
    end
  endtask

  // Every cycle, all three instances against the model
  always @(posedge CLK) begin
    #2;
    chk_vec("cycle_default", d_vec, expect_vec(m1_t, d_pulse, 800, 56, 120, 64, 600, 37, 6, 23));
    chk_vec("cycle_small", s_vec, expect_vec(m1_t, m1_pulse, SH_VIS, SH_FP, SH_SYNC, SH_BP,
                                             SV_VIS, SV_FP, SV_SYNC, SV_BP));
    chk_vec("cycle_div2", p_vec, expect_vec(m2_t, m2_pulse, SH_VIS, SH_FP, SH_SYNC, SH_BP,
                                            SV_VIS, SV_FP, SV_SYNC, SV_BP));
    if (s_iq === 1'b1) begin
      pulses_s++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_queue: got pulse cnt=%0d expected no pulse at %0t", s_cnt, $time);
      end else begin
        chk("frame_count", int'(s_cnt), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    string name;
    int    which;   // 0: dut_d, 1: dut_s
    int    t;       // ticks since release
    int    x;
    int    y;
    bit    hs;
    bit    vs;
    bit    vis;
    bit    iq;
  } vec_t;

  vec_t vecs[14];

  task automatic report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    report();
    $finish;
  end

  initial begin
    int g, tb, n, exp_cyc;

    vecs[0]  = '{"d_first",     0, 1,    0,    0, 0, 0, 1, 1};
    vecs[1]  = '{"s_last_vis",  1, 53,   7,    3, 0, 0, 1, 0};
    vecs[2]  = '{"s_vfp",       1, 61,   0,    4, 0, 0, 0, 0};
    vecs[3]  = '{"s_vsync",     1, 76,   0,    5, 0, 1, 0, 0};
    vecs[4]  = '{"s_vbp",       1, 106,  0,    7, 0, 0, 0, 0};
    vecs[5]  = '{"s_frame2",    1, 121,  0,    0, 0, 0, 1, 1};
    vecs[6]  = '{"d_x799",      0, 800,  799,  0, 0, 0, 1, 0};
    vecs[7]  = '{"d_x800",      0, 801,  800,  0, 0, 0, 0, 0};
    vecs[8]  = '{"d_x855",      0, 856,  855,  0, 0, 0, 0, 0};
    vecs[9]  = '{"d_x856",      0, 857,  856,  0, 1, 0, 0, 0};
    vecs[10] = '{"d_x975",      0, 976,  975,  0, 1, 0, 0, 0};
    vecs[11] = '{"d_x976",      0, 977,  976,  0, 0, 0, 0, 0};
    vecs[12] = '{"d_x1039",     0, 1040, 1039, 0, 0, 0, 0, 0};
    vecs[13] = '{"d_line1",     0, 1041, 0,    1, 0, 0, 1, 0};

    // Reset
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_x", int'(d_x), 0);
    chk("reset_vis", int'(d_vis), 0);
    chk("reset_cnt", int'(s_cnt), 0);
    chk("reset_iq", int'(p_iq), 0);

    RST = 1'b0;
    ABILITA = 1'b1;

    // Table vectors, ascending in t
    for (int i = 0; i < 14; i++) begin
      g = 0;
      while (m1_t != vecs[i].t && g < 3000) begin
        @(posedge CLK);
        #2;
        g++;
      end
      if (g >= 3000) begin
        chk({vecs[i].name, "_reach"}, m1_t, vecs[i].t);
      end else if (vecs[i].which == 0) begin
        chk({vecs[i].name, "_x"}, int'(d_x), vecs[i].x);
        chk({vecs[i].name, "_y"}, int'(d_y), vecs[i].y);
        chk({vecs[i].name, "_hs"}, int'(d_hs), int'(vecs[i].hs));
        chk({vecs[i].name, "_vs"}, int'(d_vs), int'(vecs[i].vs));
        chk({vecs[i].name, "_vis"}, int'(d_vis), int'(vecs[i].vis));
        chk({vecs[i].name, "_iq"}, int'(d_iq), int'(vecs[i].iq));
      end else begin
        chk({vecs[i].name, "_x"}, int'(s_x), vecs[i].x);
        chk({vecs[i].name, "_y"}, int'(s_y), vecs[i].y);
        chk({vecs[i].name, "_hs"}, int'(s_hs), int'(vecs[i].hs));
        chk({vecs[i].name, "_vs"}, int'(s_vs), int'(vecs[i].vs));
        chk({vecs[i].name, "_vis"}, int'(s_vis), int'(vecs[i].vis));
        chk({vecs[i].name, "_iq"}, int'(s_iq), int'(vecs[i].iq));
      end
    end

    // 10-cycle ABILITA=0 pulse mid-line
    repeat (20) @(negedge CLK);
    tb = m1_t;
    ABILITA = 1'b0;
    repeat (10) @(negedge CLK);
    chk("stall_x_held", int'(d_x), (tb - 1) % 1040);
    chk("stall_iq_low", int'(s_iq), 0);
    ABILITA = 1'b1;
    n = 0;
    while (n * S_FRAME + 1 <= tb) n++;
    exp_cyc = n * S_FRAME + 1 + 10;
    g = 0;
    while (s_iq !== 1'b1 && g < 400) begin
      @(posedge CLK);
      #2;
      g++;
    end
    chk("stall_frame_start_cycle", cyc, exp_cyc);

    // DIV_PIXEL=2: frame start pulse one CLK wide, X every 2nd CLK
    g = 0;
    while (p_iq !== 1'b1 && g < 600) begin
      @(posedge CLK);
      #2;
      g++;
    end
    chk("div2_iq_seen", int'(p_iq), 1);
    chk("div2_x0", int'(p_x), 0);
    chk("div2_y0", int'(p_y), 0);
    @(posedge CLK);
    #2;
    chk("div2_iq_one_clk", int'(p_iq), 0);
    chk("div2_x_hold", int'(p_x), 0);
    @(posedge CLK);
    #2;
    chk("div2_x1", int'(p_x), 1);

    // 256 frames wrap the frame counter
    g = 0;
    while (pulses_s < 256 && g < 40000) begin
      @(posedge CLK);
      #2;
      g++;
    end
    chk("frames_256_reached", pulses_s >= 256 ? 1 : 0, 1);
    chk("frames_256_cnt", int'(s_cnt), 0);

    // Asynchronous reset during both sync pulses
    g = 0;
    while (!(s_hs === 1'b1 && s_vs === 1'b1) && g < 300) begin
      @(posedge CLK);
      #2;
      g++;
    end
    chk("async_sync_found", (s_hs === 1'b1 && s_vs === 1'b1) ? 1 : 0, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_hs", int'(s_hs), 0);
    chk("async_vs", int'(s_vs), 0);
    chk("async_x", int'(s_x), 0);
    chk("async_cnt", int'(s_cnt), 0);
    chk("async_d_x", int'(d_x), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #2;
    chk("restart_x", int'(s_x), 0);
    chk("restart_y", int'(s_y), 0);
    chk("restart_vis", int'(s_vis), 1);
    chk("restart_iq", int'(s_iq), 1);
    chk("restart_cnt", int'(s_cnt), 1);

    repeat (30) @(negedge CLK);
    report();
    $finish;
  end

endmodule
